// File: rtl/pc_pkg.sv
// Shared definitions for the program counter block:
// branch-type encodings and the default instruction size.
package pc_pkg;

  localparam logic [2:0] BR_SEQ   = 3'd0;
  localparam logic [2:0] BR_B     = 3'd1;
  localparam logic [2:0] BR_CBZ   = 3'd2;
  localparam logic [2:0] BR_CBNZ  = 3'd3;
  localparam logic [2:0] BR_BCOND = 3'd4;
  localparam logic [2:0] BR_BL    = 3'd5;
  localparam logic [2:0] BR_BR    = 3'd6;
  localparam logic [2:0] BR_RET   = 3'd7;

  localparam int INSTR_B_DEF = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack.
// A push on a full stack silently overwrites the oldest entry.
module ras_stack #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [PW:0] CMAX = (PW+1)'(DEPTH);

  logic [ADDR_W-1:0] slots [DEPTH];
  logic [PW-1:0]     ptr;
  logic [PW:0]       count;
  logic [PW-1:0]     tidx;

  assign tidx  = ptr - ONE;
  assign top   = slots[tidx];
  assign empty = (count == '0);
  assign full  = (count == CMAX);

  // Pointer and occupancy; a pop on an empty stack changes nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (clear) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr   <= ptr + ONE;
      count <= full ? count : count + 1'b1;
    end else if (pop && !empty) begin
      ptr   <= tidx;
      count <= count - 1'b1;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      slots[ptr] <= din;
    end
  end

endmodule

// File: rtl/prog_counter_ras.sv
// Next-PC selection for the LEGv8 core with stall, reload,
// BL link output and a circular return-address stack.
module prog_counter_ras
  import pc_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int RAS_DEPTH = 4,
  parameter int INSTR_B = INSTR_B_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_load,
  input  logic [ADDR_W-1:0] init_value,
  input  logic              stall,
  input  logic [2:0]        br_type,
  input  logic              zero_flag,
  input  logic              cond_pass,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_addr,
  output logic              taken,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_miss
);

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] tgt_pc;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] nxt_pc;
  logic              brk;
  logic              push;
  logic              pop;
  logic              miss_nxt;
  logic              adv;

  assign seq_pc    = pc + ADDR_W'(INSTR_B);
  assign tgt_pc    = pc + br_offset;
  assign link_addr = seq_pc;
  assign adv       = !stall && !init_load;
  assign taken     = brk && adv;

  // Decode branch type into next PC, taken flag and RAS action.
  always_comb begin
    nxt_pc   = seq_pc;
    brk      = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    miss_nxt = 1'b0;
    unique case (br_type)
      BR_SEQ: ;
      BR_B: begin
        nxt_pc = tgt_pc;
        brk    = 1'b1;
      end
      BR_CBZ: begin
        brk    = zero_flag;
        nxt_pc = zero_flag ? tgt_pc : seq_pc;
      end
      BR_CBNZ: begin
        brk    = !zero_flag;
        nxt_pc = zero_flag ? seq_pc : tgt_pc;
      end
      BR_BCOND: begin
        brk    = cond_pass;
        nxt_pc = cond_pass ? tgt_pc : seq_pc;
      end
      BR_BL: begin
        nxt_pc = tgt_pc;
        brk    = 1'b1;
        push   = 1'b1;
      end
      BR_BR: begin
        nxt_pc = {reg_target[ADDR_W-1:2], 2'b00};
        brk    = 1'b1;
      end
      BR_RET: begin
        brk = 1'b1;
        if (!ras_empty) begin
          nxt_pc = {ras_top[ADDR_W-1:2], 2'b00};
          pop    = 1'b1;
        end else begin
          nxt_pc   = {reg_target[ADDR_W-1:2], 2'b00};
          miss_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  ras_stack #(
    .DEPTH  (RAS_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .clear (init_load),
    .push  (push && adv),
    .pop   (pop && adv),
    .din   (link_addr),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  // PC register: reload beats stall beats branch selection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (init_load) begin
      pc <= init_value;
    end else if (!stall) begin
      pc <= nxt_pc;
    end
  end

  // One-cycle pulse after a RET that found the stack empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_miss <= 1'b0;
    end else if (init_load) begin
      ras_miss <= 1'b0;
    end else if (!stall) begin
      ras_miss <= miss_nxt;
    end
  end

endmodule

// File: tb/tb_prog_counter_ras.sv
// Directed bench for prog_counter_ras (16-bit PC, 4-entry RAS).
// Expected values are hand-computed constants.
module tb_prog_counter_ras;
  import pc_pkg::*;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         init_load;
  logic [W-1:0] init_value;
  logic         stall;
  logic [2:0]   br_type;
  logic         zero_flag;
  logic         cond_pass;
  logic [W-1:0] br_offset;
  logic [W-1:0] reg_target;
  logic [W-1:0] pc;
  logic [W-1:0] link_addr;
  logic         taken;
  logic         ras_empty;
  logic         ras_full;
  logic         ras_miss;

  int checks = 0;
  int errors = 0;

  prog_counter_ras #(
    .ADDR_W    (W),
    .RESET_PC  (16'h0000),
    .RAS_DEPTH (4),
    .INSTR_B   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .init_load  (init_load),
    .init_value (init_value),
    .stall      (stall),
    .br_type    (br_type),
    .zero_flag  (zero_flag),
    .cond_pass  (cond_pass),
    .br_offset  (br_offset),
    .reg_target (reg_target),
    .pc         (pc),
    .link_addr  (link_addr),
    .taken      (taken),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
    .ras_miss   (ras_miss)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    init_load  = 1'b1;
    init_value = v;
    step();
    init_load  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    init_load = 1'b0; init_value = '0; stall = 1'b0;
    br_type = BR_SEQ; zero_flag = 1'b0; cond_pass = 1'b0;
    br_offset = '0; reg_target = '0;
    step(); step();
    checks++;
    if (pc !== 16'h0 || ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_miss !== 1'b0) begin
      errors++;
      $display("FAIL reset: pc=%h empty=%b full=%b miss=%b want 0000 1 0 0",
               pc, ras_empty, ras_full, ras_miss);
    end
    rst = 1'b0;
    checks++;
    if (taken !== 1'b0 || link_addr !== 16'h4) begin
      errors++;
      $display("FAIL seq_comb: taken=%b link=%h want 0 0004", taken, link_addr);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (pc !== W'(4 * i)) begin
        errors++;
        $display("FAIL seq%0d: pc=%h want %h", i, pc, W'(4 * i));
      end
    end
  endtask

  task automatic test_cond();
    load(16'h0010);
    br_type = BR_CBZ; br_offset = 16'h0020; zero_flag = 1'b1;
    #1;
    checks++;
    if (taken !== 1'b1) begin
      errors++;
      $display("FAIL cbz_taken: taken=%b want 1", taken);
    end
    step();
    checks++;
    if (pc !== 16'h0030) begin
      errors++;
      $display("FAIL cbz_pc: pc=%h want 0030", pc);
    end
    br_type = BR_CBNZ;
    #1;
    checks++;
    if (taken !== 1'b0) begin
      errors++;
      $display("FAIL cbnz_taken: taken=%b want 0", taken);
    end
    step();
    checks++;
    if (pc !== 16'h0034) begin
      errors++;
      $display("FAIL cbnz_pc: pc=%h want 0034", pc);
    end
    br_type = BR_BCOND; cond_pass = 1'b1;
    step();
    checks++;
    if (pc !== 16'h0054) begin
      errors++;
      $display("FAIL bcond_pc: pc=%h want 0054", pc);
    end
    cond_pass = 1'b0; zero_flag = 1'b0;
    step();
    checks++;
    if (pc !== 16'h0058) begin
      errors++;
      $display("FAIL bcond_nt: pc=%h want 0058", pc);
    end
    br_type = BR_BR; reg_target = 16'h0A07;
    step();
    checks++;
    if (pc !== 16'h0A04) begin
      errors++;
      $display("FAIL br_pc: pc=%h want 0A04", pc);
    end
  endtask

  task automatic test_call_ret();
    load(16'h0100);
    br_type = BR_BL; br_offset = 16'h0040;
    #1;
    checks++;
    if (link_addr !== 16'h0104 || taken !== 1'b1) begin
      errors++;
      $display("FAIL bl_comb: link=%h taken=%b want 0104 1", link_addr, taken);
    end
    step();
    checks++;
    if (pc !== 16'h0140 || ras_empty !== 1'b0) begin
      errors++;
      $display("FAIL bl_pc: pc=%h empty=%b want 0140 0", pc, ras_empty);
    end
    br_type = BR_RET; reg_target = 16'h0555;
    step();
    checks++;
    if (pc !== 16'h0104 || ras_empty !== 1'b1 || ras_miss !== 1'b0) begin
      errors++;
      $display("FAIL ret_pc: pc=%h empty=%b miss=%b want 0104 1 0",
               pc, ras_empty, ras_miss);
    end
  endtask

  task automatic test_nested();
    logic [W-1:0] exp_ret [4];
    exp_ret[0] = 16'h0604; exp_ret[1] = 16'h0504;
    exp_ret[2] = 16'h0404; exp_ret[3] = 16'h0304;
    load(16'h0200);
    br_type = BR_BL; br_offset = 16'h0100;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (pc !== W'(16'h0200 + 16'h0100 * i) || ras_full !== (i >= 4)) begin
        errors++;
        $display("FAIL nest_bl%0d: pc=%h full=%b", i, pc, ras_full);
      end
    end
    br_type = BR_RET; reg_target = 16'h0803;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (pc !== exp_ret[i] || ras_miss !== 1'b0) begin
        errors++;
        $display("FAIL nest_ret%0d: pc=%h miss=%b want %h 0",
                 i, pc, ras_miss, exp_ret[i]);
      end
    end
    checks++;
    if (ras_empty !== 1'b1) begin
      errors++;
      $display("FAIL nest_empty: empty=%b want 1", ras_empty);
    end
    step();
    checks++;
    if (pc !== 16'h0800 || ras_miss !== 1'b1) begin
      errors++;
      $display("FAIL ret_miss: pc=%h miss=%b want 0800 1", pc, ras_miss);
    end
    br_type = BR_SEQ;
    step();
    checks++;
    if (pc !== 16'h0804 || ras_miss !== 1'b0 || ras_empty !== 1'b1) begin
      errors++;
      $display("FAIL miss_clr: pc=%h miss=%b empty=%b want 0804 0 1",
               pc, ras_miss, ras_empty);
    end
  endtask

  task automatic test_stall();
    br_type = BR_BL; br_offset = 16'h0010;
    step();
    checks++;
    if (pc !== 16'h0814 || ras_empty !== 1'b0) begin
      errors++;
      $display("FAIL pre_stall: pc=%h empty=%b want 0814 0", pc, ras_empty);
    end
    stall = 1'b1; br_type = BR_B; br_offset = 16'h0040;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) br_type = BR_RET;
      #1;
      checks++;
      if (taken !== 1'b0) begin
        errors++;
        $display("FAIL stall_taken%0d: taken=%b want 0", i, taken);
      end
      step();
      checks++;
      if (pc !== 16'h0814 || ras_empty !== 1'b0 || ras_miss !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: pc=%h empty=%b want 0814 0",
                 i, pc, ras_empty);
      end
    end
    br_type = BR_B;
    init_load = 1'b1; init_value = 16'h2000;
    #1;
    checks++;
    if (taken !== 1'b0) begin
      errors++;
      $display("FAIL load_taken: taken=%b want 0", taken);
    end
    step();
    init_load = 1'b0; stall = 1'b0;
    checks++;
    if (pc !== 16'h2000 || ras_empty !== 1'b1) begin
      errors++;
      $display("FAIL load_pc: pc=%h empty=%b want 2000 1", pc, ras_empty);
    end
  endtask

  task automatic test_wrap_reset();
    load(16'hFFFC);
    br_type = BR_SEQ;
    step();
    checks++;
    if (pc !== 16'h0000) begin
      errors++;
      $display("FAIL wrap: pc=%h want 0000", pc);
    end
    load(16'h1230);
    br_type = BR_BL; br_offset = 16'h0040;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (pc !== 16'h0000 || ras_empty !== 1'b1) begin
      errors++;
      $display("FAIL async_rst: pc=%h empty=%b want 0000 1", pc, ras_empty);
    end
    step();
    rst = 1'b0;
    br_type = BR_SEQ;
    checks++;
    if (pc !== 16'h0000 || ras_empty !== 1'b1 || ras_full !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold: pc=%h empty=%b want 0000 1", pc, ras_empty);
    end
    step();
    checks++;
    if (pc !== 16'h0004) begin
      errors++;
      $display("FAIL post_rst: pc=%h want 0004", pc);
    end
  endtask

  initial begin
    test_reset();
    test_cond();
    test_call_ret();
    test_nested();
    test_stall();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
